// File: rtl/fifo_pkg.sv
// Shared defaults and word type for the I2C/UART bridge byte FIFO.
package fifo_pkg;
    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 16;

    typedef logic [FIFO_WIDTH-1:0] word_t;
endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with a synchronous write port and a registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_WIDTH,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Contents are deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Reads the pre-edge contents, so a same-cycle write to the read slot is not bypassed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/fifo.sv
// Single-clock byte FIFO between the I2C and UART sides; pointers, occupancy and error flags.
module fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             en_write,
    input  logic             en_read,
    output logic [WIDTH-1:0] data_out,
    output logic             overflow,
    output logic             underflow
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              full, empty, wr_acc, rd_acc;

    assign full  = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

    // When full, a same-cycle read frees the slot the write lands in.
    assign rd_acc = en_read & ~empty;
    assign wr_acc = en_write & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
        ovf_d = en_write & full & ~en_read;
        udf_d = en_read & empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk      (clk),
        .rst      (reset),
        .wr_en_i  (wr_acc),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(data_in),
        .rd_en_i  (rd_acc),
        .rd_addr_i(rd_ptr_q),
        .rd_data_o(data_out)
    );

    assign overflow  = ovf_q;
    assign underflow = udf_q;
endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed steps plus random traffic against a queue model.
module tb_fifo;
    import fifo_pkg::*;

    localparam int DEPTH = FIFO_DEPTH;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    word_t data_in = '0;
    logic  en_write = 1'b0;
    logic  en_read = 1'b0;
    word_t data_out;
    logic  overflow;
    logic  underflow;

    int checks = 0;
    int errors = 0;

    word_t q[$];
    word_t exp_dout = '0;
    logic  exp_ovf = 1'b0;
    logic  exp_udf = 1'b0;

    fifo dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .en_write (en_write),
        .en_read  (en_read),
        .data_out (data_out),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"}, data_out, exp_dout);
        check({tag, ".overflow"}, {7'd0, overflow}, {7'd0, exp_ovf});
        check({tag, ".underflow"}, {7'd0, underflow}, {7'd0, exp_udf});
    endtask

    // Called at a falling edge; applies one cycle of requests and checks the result.
    task automatic step(input logic we, input logic re, input word_t d, input string tag);
        int  n;
        logic rd_ok, wr_ok;
        en_write = we;
        en_read  = re;
        data_in  = d;
        @(posedge clk);
        n       = q.size();
        exp_ovf = we && (n == DEPTH) && !re;
        exp_udf = re && (n == 0);
        rd_ok   = re && (n > 0);
        wr_ok   = we && ((n < DEPTH) || rd_ok);
        if (rd_ok) exp_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    word_t fill_vals[15];

    initial begin
        // Power-on reset checked before any clock edge.
        #1 reset = 1'b1;
        #2;
        model_reset();
        check_all("reset_async");
        @(negedge clk);
        reset = 1'b0;

        // Empty read: underflow pulse, data_out stays zero.
        step(1'b0, 1'b1, 8'h00, "empty_read");
        step(1'b0, 1'b0, 8'h00, "empty_idle");

        // Simultaneous write/read while empty: write kept, read rejected.
        step(1'b1, 1'b1, 8'hA5, "empty_wr_rd");
        step(1'b0, 1'b1, 8'h00, "read_a5");
        check("a5_value", data_out, 8'hA5);
        step(1'b0, 1'b0, 8'h00, "idle1");

        // Fill 15, then drain 15.
        fill_vals[0] = 8'h24; fill_vals[1] = 8'h81; fill_vals[2] = 8'h09; fill_vals[3] = 8'h63;
        for (int i = 4; i < 15; i++) fill_vals[i] = word_t'($urandom);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, fill_vals[i], "fill15");
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, 8'h00, "drain15");
            check("drain_seq", data_out, fill_vals[i]);
        end
        step(1'b0, 1'b0, 8'h00, "idle2");

        // Full: 16 words, 17th overflows and is dropped.
        step(1'b1, 1'b0, 8'h3C, "full_w0");
        for (int i = 1; i < DEPTH; i++) step(1'b1, 1'b0, word_t'($urandom), "full_fill");
        step(1'b1, 1'b0, 8'hEE, "write17");
        step(1'b1, 1'b1, 8'h77, "full_wr_rd");
        check("first_read_word0", data_out, 8'h3C);
        step(1'b1, 1'b0, 8'h55, "still_full");

        // Mid-cycle reset while overflow is high clears outputs without a clock edge.
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b1, 8'h00, "after_reset_read");

        // Pointer wrap with a half-full FIFO.
        for (int i = 0; i < DEPTH / 2; i++) step(1'b1, 1'b0, word_t'($urandom), "half_fill");
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, word_t'($urandom), "wrap");
            checks++;
            assert (q.size() == DEPTH / 2) else begin
                errors++;
                $error("FAIL wrap_level observed %0d expected %0d", q.size(), DEPTH / 2);
            end
        end

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 1'($urandom), word_t'($urandom), "random");
        end
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 8'h00, "final_drain");
        step(1'b0, 1'b0, 8'h00, "final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
